// File: rtl/rle_pkg.sv
// Shared definitions for the run-length codec pair: decoder FSM encoding,
// stream geometry constants and a byte-lane extract helper.
package rle_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int PAIR_BYTES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXPAND,
        S_WRITE,
        S_FLUSH_RD,
        S_FLUSH_WR,
        S_DONE
    } rld_state_t;

    function automatic logic [BYTE_W-1:0] get_lane(input logic [31:0] word,
                                                   input logic [1:0]  lane);
        return word[lane*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/rld_fast_if.sv
// Single-port DPSRAM bus shared by the run-length compressor and decoder.
interface rld_fast_if #(parameter int ADDR_W = 16);

    logic              port_A_clk;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;
    logic [ADDR_W-1:0] port_A_addr;
    logic              port_A_we;

    modport master (
        output port_A_clk,
        output port_A_data_in,
        output port_A_addr,
        output port_A_we,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_data_in,
        input  port_A_addr,
        input  port_A_we,
        output port_A_data_out
    );

endinterface

// File: rtl/rld_pack.sv
// Four-byte output packer: collects decoded bytes low lane first and offers
// a merge of its valid lanes over a read-back word for the final partial write.
module rld_pack
    import rle_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  data,
    input  logic [31:0] readback,
    output logic [31:0] word,
    output logic [2:0]  count,
    output logic        full,
    output logic [31:0] merged
);

    logic [31:0] word_q;
    logic [2:0]  count_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            word_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            word_q  <= '0;
            count_q <= '0;
        end else if (push) begin
            word_q[count_q[1:0]*BYTE_W +: BYTE_W] <= data;
            count_q                               <= count_q + 3'd1;
        end
    end

    always_comb begin
        merged = readback;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i < int'(count_q)) merged[i*BYTE_W +: BYTE_W] = word_q[i*BYTE_W +: BYTE_W];
        end
    end

    assign word  = word_q;
    assign count = count_q;
    assign full  = (count_q == 3'(WORD_BYTES));

endmodule

// File: rtl/rld_fast.sv
// Run-length decoder: expands {count, value} byte pairs read from DPSRAM into
// plaintext bytes, written back word by word with a read-merge final word.
module rld_fast
    import rle_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_COUNT = 255
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] message_addr,
    output logic [31:0] message_size,
    output logic        done,
    rld_fast_if.master  mem
);

    localparam int RUN_W = $clog2(MAX_COUNT + 1);

    rld_state_t        state_q, state_d;

    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       bytes_left_q;
    logic [RUN_W-1:0]  run_q;
    logic [7:0]        val_q;
    logic [7:0]        cnt2_q;
    logic [7:0]        val2_q;
    logic              pair_sel_q;
    logic              two_pairs_q;
    logic              flush_phase_q;
    logic [31:0]       rb_q;
    logic [31:0]       msg_size_q;

    logic              pk_clr;
    logic              pk_push;
    logic [31:0]       pk_word;
    logic [2:0]        pk_count;
    logic              pk_full;
    logic [31:0]       pk_merged;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    rld_pack u_pack (
        .clk      (clk),
        .nreset   (nreset),
        .clr      (pk_clr),
        .push     (pk_push),
        .data     (val_q),
        .readback (rb_q),
        .word     (pk_word),
        .count    (pk_count),
        .full     (pk_full),
        .merged   (pk_merged)
    );

    always_ff @(posedge clk) begin
        if (!nreset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pk_push   = 1'b0;
        pk_clr    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pk_clr  = 1'b1;
                    state_d = (rle_size == 32'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                mem_addr = rd_addr_q;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Address is held so the read word stays stable for capture.
                mem_addr = rd_addr_q;
                state_d  = S_EXPAND;
            end
            S_EXPAND: begin
                if (run_q != '0) begin
                    pk_push = 1'b1;
                    if (pk_count == 3'(WORD_BYTES - 1)) state_d = S_WRITE;
                end else if (!pair_sel_q && two_pairs_q) begin
                    state_d = S_EXPAND;
                end else if (bytes_left_q != 32'd0) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FLUSH_RD;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = wr_addr_q;
                mem_wdata = pk_word;
                pk_clr    = pk_full;
                state_d   = S_EXPAND;
            end
            S_FLUSH_RD: begin
                if (pk_count == 3'd0) begin
                    state_d = S_DONE;
                end else begin
                    mem_addr = wr_addr_q;
                    if (flush_phase_q) state_d = S_FLUSH_WR;
                end
            end
            S_FLUSH_WR: begin
                mem_we    = 1'b1;
                mem_addr  = wr_addr_q;
                mem_wdata = pk_merged;
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: there is no RAM inside this block, so every register, including
    // the pair and read-back buffers, is cleared by reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            bytes_left_q  <= '0;
            run_q         <= '0;
            val_q         <= '0;
            cnt2_q        <= '0;
            val2_q        <= '0;
            pair_sel_q    <= 1'b0;
            two_pairs_q   <= 1'b0;
            flush_phase_q <= 1'b0;
            rb_q          <= '0;
            msg_size_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rd_addr_q     <= {rle_addr[ADDR_W-1:2], 2'b00};
                        wr_addr_q     <= {message_addr[ADDR_W-1:2], 2'b00};
                        bytes_left_q  <= rle_size;
                        msg_size_q    <= '0;
                        run_q         <= '0;
                        pair_sel_q    <= 1'b0;
                        flush_phase_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    run_q       <= RUN_W'(get_lane(mem.port_A_data_out, 2'd0));
                    val_q       <= get_lane(mem.port_A_data_out, 2'd1);
                    cnt2_q      <= get_lane(mem.port_A_data_out, 2'd2);
                    val2_q      <= get_lane(mem.port_A_data_out, 2'd3);
                    pair_sel_q  <= 1'b0;
                    rd_addr_q   <= rd_addr_q + ADDR_W'(WORD_BYTES);
                    two_pairs_q <= (bytes_left_q >= 32'(WORD_BYTES));
                    if (bytes_left_q >= 32'(WORD_BYTES))
                        bytes_left_q <= bytes_left_q - 32'(WORD_BYTES);
                    else
                        bytes_left_q <= '0;
                end
                S_EXPAND: begin
                    if (run_q != '0) begin
                        run_q <= run_q - RUN_W'(1);
                        if (msg_size_q != '1) msg_size_q <= msg_size_q + 32'd1;
                    end else if (!pair_sel_q && two_pairs_q) begin
                        run_q      <= RUN_W'(cnt2_q);
                        val_q      <= val2_q;
                        pair_sel_q <= 1'b1;
                    end
                end
                S_WRITE: wr_addr_q <= wr_addr_q + ADDR_W'(WORD_BYTES);
                S_FLUSH_RD: begin
                    if (pk_count != 3'd0) begin
                        flush_phase_q <= 1'b1;
                        if (flush_phase_q) rb_q <= mem.port_A_data_out;
                    end
                end
                S_FLUSH_WR: flush_phase_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign mem.port_A_clk     = ~clk;
    assign mem.port_A_we      = mem_we;
    assign mem.port_A_addr    = mem_addr;
    assign mem.port_A_data_in = mem_wdata;

    assign done         = (state_q == S_DONE);
    assign message_size = msg_size_q;

endmodule
